// File: rtl/packetizer_row.sv
// packetizer_row: gathers three FILTER_WIDTH elements of one row, stamps the
// row with its type, timestep and row index, and offers it downstream as a
// single packet. Accepting and sending alternate and never overlap.
//
// Packet layout (3*FILTER_WIDTH+4 bits):
//   [0]    timestep
//   [1]    ifmapb_filter (1 = filter row, 0 = ifmap row)
//   [3:2]  filter_row (row index within the current frame)
//   [4+k*FILTER_WIDTH +: FILTER_WIDTH]  element k, k = 0..2
//
// Optional feature: define PKTZ_AUTO_TS_EN to take the timestep from an
// internal bit that toggles on every frame_done. When it is not defined, the
// timestep is in_ts sampled with element 0.
//
// NUM_ROWS must be in 1..4 because the filter_row field is two bits wide.

module packetizer_row #(
  parameter int FILTER_WIDTH = 8,
  parameter int NUM_ROWS     = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [FILTER_WIDTH-1:0]   in_data,
  input  logic                      in_is_filter,
  input  logic                      in_ts,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [3*FILTER_WIDTH+3:0] out_packet,
  output logic                      frame_done
);

  localparam logic [1:0] ROW_LAST = 2'(NUM_ROWS - 1);

  typedef enum logic {COLLECT, SEND} state_t;

  state_t                    r_state;
  logic [1:0]                r_elem;        // next element slot, 0..2
  logic [1:0]                r_row;         // row index within the frame
  logic                      r_frame_type;  // type of the frame in progress
  logic [3*FILTER_WIDTH+3:0] r_packet;

  logic w_handshake;
  logic w_last_row;
  logic w_type_change;
  logic w_ts;

`ifdef PKTZ_AUTO_TS_EN
  logic r_ts;  // internal timestep, flips once per completed frame
  assign w_ts = r_ts;
`else
  assign w_ts = in_ts;
`endif

  assign w_handshake   = (r_state == SEND) && out_ready;
  assign w_last_row    = (r_row == ROW_LAST);
  // A row of the other type arriving mid-frame abandons that frame.
  assign w_type_change = (r_row != 2'd0) && (in_is_filter != r_frame_type);

  // NOTE: rst is gated into these combinational outputs so that in_ready and
  // frame_done are low during the reset cycle itself, not only one cycle later.
  assign in_ready   = (r_state == COLLECT) && !rst;
  assign out_valid  = (r_state == SEND);
  assign frame_done = w_handshake && w_last_row && !rst;
  assign out_packet = r_packet;

  // Row assembly, packet handshake and frame bookkeeping.
  // NOTE: every state register here uses non-blocking assignment so that all
  // right-hand sides see the values from before this clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the packet register is reset as well, so out_packet reads 0
      // after reset rather than holding a stale row.
      r_state      <= COLLECT;
      r_elem       <= 2'd0;
      r_row        <= 2'd0;
      r_frame_type <= 1'b0;
      r_packet     <= '0;
`ifdef PKTZ_AUTO_TS_EN
      r_ts         <= 1'b0;
`endif
    end else begin
      case (r_state)
        COLLECT: begin
          if (in_valid) begin
            for (int k = 0; k < 3; k++) begin
              if (r_elem == 2'(k)) begin
                r_packet[4+k*FILTER_WIDTH +: FILTER_WIDTH] <= in_data;
              end
            end
            if (r_elem == 2'd0) begin
              r_packet[0]   <= w_ts;
              r_packet[1]   <= in_is_filter;
              r_packet[3:2] <= w_type_change ? 2'd0 : r_row;
              r_frame_type  <= in_is_filter;
              if (w_type_change) begin
                r_row <= 2'd0;
              end
            end
            if (r_elem == 2'd2) begin
              r_elem  <= 2'd0;
              r_state <= SEND;
            end else begin
              r_elem <= r_elem + 2'd1;
            end
          end
        end
        SEND: begin
          if (out_ready) begin
            r_state <= COLLECT;
            r_row   <= w_last_row ? 2'd0 : r_row + 2'd1;
`ifdef PKTZ_AUTO_TS_EN
            if (w_last_row) begin
              r_ts <= ~r_ts;
            end
`endif
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_packetizer_row.sv
// Self-checking bench for packetizer_row. A frame-level reference model
// (rows completed in the current frame, frame type, timestep) predicts every
// packet and every frame_done pulse. Outputs are sampled on the falling edge.

module tb_packetizer_row;

  localparam int W  = 8;
  localparam int NR = 3;
  localparam int PW = 3 * W + 4;
`ifdef PKTZ_AUTO_TS_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_is_filter;
  logic          in_ts;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_packet;
  logic          frame_done;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int m_rows;  // rows already sent in the current frame
  bit m_type;  // type of the current frame
  bit m_ts;    // internal timestep (only meaningful with auto timestep)

  packetizer_row #(.FILTER_WIDTH(W), .NUM_ROWS(NR)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_is_filter (in_is_filter),
    .in_ts        (in_ts),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_packet   (out_packet),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one element after 'gap' idle cycles; it must be accepted at once.
  task automatic push_elem(input logic [W-1:0] d, input bit f, input bit t, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid     = 1'b1;
    in_data      = d;
    in_is_filter = f;
    in_ts        = t;
    check("in_ready_collect", in_ready, 1);
    check("out_valid_collect", out_valid, 0);
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    in_data      = W'($urandom);
    in_is_filter = 1'($urandom);
    in_ts        = 1'($urandom);
  endtask

  // Send one complete row, hold out_ready low 'hold' cycles, then accept it.
  task automatic do_row(input logic [W-1:0] d0, input logic [W-1:0] d1,
                        input logic [W-1:0] d2, input bit f, input bit t,
                        input int hold, input int gap_max);
    logic [PW-1:0] exp_pkt;
    logic [1:0]    exp_row;
    bit            exp_done;
    if (m_rows != 0 && f != m_type) m_rows = 0;
    m_type  = f;
    exp_row = 2'(m_rows);
    exp_pkt = {d2, d1, d0, exp_row, f, (AUTO ? m_ts : t)};

    push_elem(d0, f, t, $urandom_range(gap_max, 0));
    // Elements 1 and 2 carry random type/timestep bits that must be ignored.
    push_elem(d1, 1'($urandom), 1'($urandom), $urandom_range(gap_max, 0));
    push_elem(d2, 1'($urandom), 1'($urandom), $urandom_range(gap_max, 0));

    @(negedge clk);
    check("out_valid_latency", out_valid, 1);
    check("in_ready_send", in_ready, 0);
    check("packet", out_packet, exp_pkt);
    check("frame_done_idle", frame_done, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_packet", out_packet, exp_pkt);
      check("hold_frame_done", frame_done, 0);
    end
    out_ready = 1'b1;
    exp_done  = (m_rows == NR - 1);
    #1;
    check("frame_done_handshake", frame_done, exp_done);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    m_rows++;
    if (exp_done) begin
      m_rows = 0;
      m_ts   = ~m_ts;
    end
    @(negedge clk);
    check("out_valid_after_hs", out_valid, 0);
    check("in_ready_after_hs", in_ready, 1);
    check("frame_done_after_hs", frame_done, 0);
  endtask

  // Pulse reset for one edge and check the reset outputs.
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("in_ready_in_rst", in_ready, 0);
    check("frame_done_in_rst", frame_done, 0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    m_rows = 0;
    m_type = 1'b0;
    m_ts   = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_out_packet", out_packet, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    in_is_filter = 1'b0;
    in_ts        = 1'b0;
    out_ready    = 1'b0;
    m_rows       = 0;
    m_type       = 1'b0;
    m_ts         = 1'b0;

    // Power-on reset.
    repeat (2) @(negedge clk);
    check("por_in_ready", in_ready, 0);
    pulse_reset();

    // Directed row 0x11/0x22/0x33, filter, ts=1; then two more rows closing
    // the frame, then a fourth row that must be stamped row 0.
    do_row(8'h11, 8'h22, 8'h33, 1'b1, 1'b1, 0, 0);
    do_row(W'($urandom), W'($urandom), W'($urandom), 1'b1, 1'b1, 0, 0);
    do_row(W'($urandom), W'($urandom), W'($urandom), 1'b1, 1'b1, 0, 0);
    do_row(W'($urandom), W'($urandom), W'($urandom), 1'b1, 1'b0, 0, 0);

    // Backpressure: out_ready low for 5 cycles in SEND.
    do_row(W'($urandom), W'($urandom), W'($urandom), 1'b1, 1'b0, 5, 0);

    // Type change mid-frame: filter, filter, then ifmap restarts at row 0.
    pulse_reset();
    do_row(W'($urandom), W'($urandom), W'($urandom), 1'b1, 1'b0, 0, 0);
    do_row(W'($urandom), W'($urandom), W'($urandom), 1'b1, 1'b0, 0, 0);
    do_row(W'($urandom), W'($urandom), W'($urandom), 1'b0, 1'b0, 0, 0);

    // Reset after two accepted elements discards the row.
    push_elem(W'($urandom), 1'b1, 1'b1, 0);
    push_elem(W'($urandom), 1'b1, 1'b1, 0);
    pulse_reset();
    check("no_packet_after_rst", out_valid, 0);
    do_row(W'($urandom), W'($urandom), W'($urandom), 1'b1, 1'b1, 0, 0);

    // Reset while a packet is pending discards it.
    push_elem(W'($urandom), 1'b0, 1'b1, 0);
    push_elem(W'($urandom), 1'b0, 1'b1, 0);
    push_elem(W'($urandom), 1'b0, 1'b1, 0);
    @(negedge clk);
    check("pending_valid", out_valid, 1);
    pulse_reset();

    // Two full frames with in_ts=0 (timestep source check).
    for (int i = 0; i < 2 * NR; i++) begin
      do_row(W'($urandom), W'($urandom), W'($urandom), 1'b0, 1'b0, 0, 0);
    end

    // Randomized rows: mostly same type, random stalls and backpressure.
    for (int i = 0; i < 30; i++) begin
      do_row(W'($urandom), W'($urandom), W'($urandom),
             ($urandom_range(3, 0) == 0) ? ~m_type : m_type, 1'($urandom),
             $urandom_range(2, 0), 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
